// File: rtl/l0_rd_sequencer.sv
// rtl/l0_rd_sequencer.sv - staggered read sequencer for the per-row L0 FIFO bank
// Row r reads len vectors starting r cycles after row 0; any due-but-empty row stalls all rows.
module l0_rd_sequencer #(
  parameter int row    = 8,
  parameter int len_bw = 7,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [len_bw-1:0] len,
  input  logic [row-1:0]    empty_row,
  output logic [row-1:0]    rd_row,
  output logic              busy,
  output logic              done,
  output logic [cnt_bw-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [cnt_bw-1:0] cyc, cyc_d;
  logic [cnt_bw-1:0] stall_cnt_d;
  logic [len_bw-1:0] len_q, len_q_d;
  logic [cnt_bw-1:0] len_ext;
  logic [cnt_bw-1:0] last_cyc;
  logic [row-1:0]    active;
  logic              stall;

  assign len_ext  = cnt_bw'(len_q);
  assign last_cyc = len_ext + cnt_bw'(row - 2);

  // Row r's read window is [r, r+len_q) in sequence cycles.
  always_comb begin
    active = '0;
    for (int r = 0; r < row; r++) begin
      active[r] = (cyc >= cnt_bw'(r)) && (cyc < cnt_bw'(r) + len_ext);
    end
  end

  assign stall = |(active & empty_row);

  always_comb begin
    state_d     = state;
    cyc_d       = cyc;
    len_q_d     = len_q;
    stall_cnt_d = stall_cnt;
    rd_row      = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_q_d     = len;
            cyc_d       = '0;
            stall_cnt_d = '0;
            state_d     = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (stall) begin
          if (stall_cnt != {cnt_bw{1'b1}}) begin
            stall_cnt_d = stall_cnt + cnt_bw'(1);
          end
        end else begin
          rd_row = active;
          cyc_d  = cyc + cnt_bw'(1);
          if (cyc == last_cyc) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cyc       <= '0;
      len_q     <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_d;
      cyc       <= cyc_d;
      len_q     <= len_q_d;
      stall_cnt <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_l0_rd_sequencer.sv
// tb/tb_l0_rd_sequencer.sv - directed scoreboard bench for l0_rd_sequencer
module tb_l0_rd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] len;
  logic [7:0] empty_row;
  logic [7:0] rd_row;
  logic       busy;
  logic       done;
  logic [7:0] stall_cnt;

  typedef struct {
    logic [7:0] rd;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   rd_cnt[8];
  int   fcnt[8];
  int   fptr[8];
  int   busy_cyc;
  int   guard;
  int   exp_stall;
  int   total;
  logic seen_done;

  always #5 clk = ~clk;

  l0_rd_sequencer #(.row(8), .len_bw(7), .cnt_bw(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .empty_row (empty_row),
    .rd_row    (rd_row),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] vec(input int k, input int l);
    logic [7:0] v;
    v = '0;
    for (int r = 0; r < 8; r++) begin
      if (k >= r && k < r + l) v[r] = 1'b1;
    end
    return v;
  endfunction

  // Drive one cycle of inputs, queue what the DUT must show this cycle, compare at negedge.
  task automatic tick(input logic st, input logic [6:0] ln, input logic [7:0] emp,
                      input logic [7:0] e_rd, input logic e_busy, input logic e_done);
    exp_t e;
    start     = st;
    len       = ln;
    empty_row = emp;
    e.rd      = e_rd;
    e.busy    = e_busy;
    e.done    = e_done;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check("rd_row", 32'(rd_row), 32'(e.rd));
    check("busy", 32'(busy), 32'(e.busy));
    check("done", 32'(done), 32'(e.done));
    check("rd_while_empty", 32'(rd_row & empty_row), 32'h0);
    for (int r = 0; r < 8; r++) begin
      if (rd_row[r]) rd_cnt[r]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input int l, input int stall_k, input int stall_n,
                         input logic [7:0] mask, input int restart_k, input string name);
    for (int r = 0; r < 8; r++) rd_cnt[r] = 0;
    tick(1'b1, 7'(l), 8'h00, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < l + 7; k++) begin
      if (k == stall_k) begin
        for (int s = 0; s < stall_n; s++) tick(1'b0, 7'(l), mask, 8'h00, 1'b1, 1'b0);
      end
      tick(k == restart_k, (k == restart_k) ? 7'd9 : 7'(l), 8'h00, vec(k, l), 1'b1, 1'b0);
    end
    tick(1'b0, 7'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 7'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) check({name, "_reads"}, 32'(rd_cnt[r]), 32'(l));
    check({name, "_stall_cnt"}, 32'(stall_cnt), 32'(stall_n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    len       = 7'd0;
    empty_row = 8'h00;
    @(posedge clk);
    #1;
    check("reset_rd_row", 32'(rd_row), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Plain len=4 sequence: 11 RUN cycles, done 12 cycles after start
    run_seq(4, -1, 0, 8'h00, -1, "t1");
    total = 0;
    for (int r = 0; r < 8; r++) total += rd_cnt[r];
    check("t1_total_reads", 32'(total), 32'd32);

    // Row 3 empty for two cycles at cyc=4
    run_seq(4, 4, 2, 8'h08, -1, "t2");

    // len=0 goes straight to done
    tick(1'b1, 7'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 7'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 7'd0, 8'h00, 8'h00, 1'b0, 1'b0);

    // start with len=9 during RUN is ignored
    run_seq(4, -1, 0, 8'h00, 2, "t4");

    // Async reset mid-sequence
    for (int r = 0; r < 8; r++) rd_cnt[r] = 0;
    tick(1'b1, 7'd4, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick(1'b0, 7'd4, 8'h00, vec(k, 4), 1'b1, 1'b0);
    check("t5_pre_reset_rd", 32'(rd_row), 32'(vec(5, 4)));
    #2;
    reset = 1'b1;
    #1;
    check("t5_reset_rd_row", 32'(rd_row), 32'h0);
    check("t5_reset_busy", 32'(busy), 32'h0);
    check("t5_reset_done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_seq(4, -1, 0, 8'h00, -1, "t5");

    // len=100 against a FIFO occupancy model with a random-rate writer
    for (int r = 0; r < 8; r++) begin
      fcnt[r] = (r % 3) * 4;
      fptr[r] = 0;
    end
    busy_cyc  = 0;
    seen_done = 1'b0;
    guard     = 0;
    while (!seen_done && guard < 5000) begin
      start = (guard == 0);
      len   = 7'd100;
      for (int r = 0; r < 8; r++) empty_row[r] = (fcnt[r] == 0);
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) seen_done = 1'b1;
      check("t6_rd_while_empty", 32'(rd_row & empty_row), 32'h0);
      for (int r = 0; r < 8; r++) begin
        if (rd_row[r]) begin
          fcnt[r]--;
          fptr[r]++;
        end
        if (fcnt[r] < 64 && $urandom_range(0, 1) == 1) fcnt[r]++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    start = 1'b0;
    check("t6_done_seen", 32'(seen_done), 32'h1);
    for (int r = 0; r < 8; r++) check("t6_rd_ptr", 32'(fptr[r]), 32'd100);
    exp_stall = busy_cyc - 107;
    if (exp_stall > 255) exp_stall = 255;
    check("t6_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
